sw_array_driver: RTL and testbench
==================================

// Module: sw_array_driver
// PURPOSE
// Feeder/collector at the head and tail of the affine Smith-Waterman systolic PE chain. Accepts a
// query (N_PE nucleotides) and drives the per-PE preload bus. Resets the array, then streams a target
// sequence into PE0 with a gapless valid. Tracks the last PE's running-high output and returns one
// unbiased best score per job over a valid/ready result port.
// PARAMETERS
// N_PE        48    number of PEs in the chain; query length is exactly N_PE
// SCORE_WIDTH 11    PE score width; neutral (zero) score = 1<<(SCORE_WIDTH-1) = 0x400
// TLEN_W      16    width of the target-length counter (max 2^TLEN_W-1 chars)
// DRAIN_PAD   4     extra drain cycles allowed beyond N_PE before timeout
// PORTS
// clk         in   1            clock
// i_rst       in   1            reset, synchronous, active-high
// i_local     in   1            1=local alignment; sampled in IDLE when a job starts
// s_q_data    in   2            query char (A=00 G=01 T=10 C=11)
// s_q_vld     in   1            query char valid
// s_q_last    in   1            marks final query char
// s_q_rdy     out  1            driver accepts query char
// s_t_data    in   2            target char
// s_t_vld     in   1            target char valid
// s_t_last    in   1            marks final target char
// s_t_rdy     out  1            driver accepts target char
// o_arr_rst   out  1            reset into PE0 (ripples down the chain)
// o_arr_data  out  2            char into PE0 i_data
// o_arr_vld   out  1            valid into PE0 i_vld
// o_arr_local out  1            i_local to all PEs
// o_arr_preload out 2*N_PE      PE k preload = bits [2k+1:2k]
// i_arr_high  in   SCORE_WIDTH  o_high of last PE
// i_arr_vld   in   1            o_vld of last PE
// m_score     out  SCORE_WIDTH-1 best score minus neutral, floored at 0
// m_err       out  2            00 ok, 01 query length, 10 target underrun, 11 drain timeout
// m_vld       out  1            result valid; held until m_rdy
// m_rdy       in   1            result consumer ready
// BEHAVIOUR
// Reset: state=IDLE; o_arr_rst=1; s_q_rdy=s_t_rdy=m_vld=o_arr_vld=0; o_arr_data=0; preload=0;
//   m_score=0; m_err=0; o_arr_local=0; running max=0x400.
// States:
// IDLE: latch i_local->o_arr_local; go ARST. o_arr_rst=1.
// ARST: o_arr_rst=1 for N_PE+1 cycles, then 0 for 2 cycles (PE state 00->01). Then LOADQ.
// LOADQ: s_q_rdy=1. Each handshake shifts the char in; 1st accepted char ends in PE0 slot after N_PE
//   chars. s_q_last on char N_PE -> STREAM. Early last, or N_PE-th char without last -> m_err=01,
//   REPORT (remaining chars of the bad query are not consumed).
// STREAM: s_t_rdy=1. o_arr_vld/o_arr_data register the accepted char (1-cycle latency).
//   Once the first char is accepted, s_t_vld=0 before s_t_last -> o_arr_vld drops, m_err=10, DRAIN.
//   Handshake with s_t_last -> next cycle o_arr_vld=0, go DRAIN. Count saturates at 2^TLEN_W-1;
//   at saturation the char is forced as last.
// DRAIN: o_arr_vld=0. Wait for i_arr_vld 1->0 after at least one 1, then REPORT.
//   If N_PE+DRAIN_PAD cycles pass first -> m_err=11, REPORT.
// REPORT: m_vld=1; m_score, m_err stable until m_rdy. Handshake -> IDLE (new job re-resets the array).
// Running max: cleared to 0x400 on ARST entry; max(max, i_arr_high) every cycle i_arr_vld=1.
// Compares are unsigned (biased encoding).
// m_score = max>=0x400 ? max-0x400 : 0. Global mode uses the same formula (negatives floor to 0).
// i_rst at any time aborts the job and returns to reset values within one cycle; no result emitted.
// Simultaneous s_q_last and the length error: error wins.
// STRUCTURE
// Package sw_pkg: SCORE_WIDTH, NEUTRAL_SCORE, nucleotide codes, GOPEN/GEXT, match/mismatch, err codes,
//   state enum.
// One sub-module, sw_preload_shifter: 2*N_PE-bit shift register with shift-enable and clear.
// FSM, counters, drain timer and max tracker stay in the top.
// TESTING (N_PE=4, local; bench models the chain with 4 sw_pe_affine instances)
// 1. Query AGTC, target AGTC gapless -> m_score=20, m_err=00, one m_vld pulse.
// 2. Query AAAA, target TTTT -> m_score=0, m_err=00.
// 3. Query with last on 3rd char -> m_err=01, no o_arr_vld asserted, s_t_rdy never 1.
// 4. Target ACGT with s_t_vld low 1 cycle after 2nd char -> m_err=10, o_arr_vld low the next cycle.
// 5. m_rdy low 10 cycles in REPORT -> m_vld/m_score stable, then one handshake and back to IDLE.
// 6. i_rst mid-STREAM -> o_arr_rst=1, o_arr_vld=0 next cycle; next job (AGTC/AGTC) scores 20.

Source files
------------

// File: rtl/sw_array_driver_pkg.sv
// Shared types and constants for the Smith-Waterman array driver and its PE chain.
// Scores are biased: NEUTRAL_SCORE represents zero, so all compares are unsigned.
package sw_pkg;

  localparam int SCORE_WIDTH = 11;
  localparam logic [SCORE_WIDTH-1:0] NEUTRAL_SCORE = 11'h400;

  localparam logic [1:0] NT_A = 2'b00;
  localparam logic [1:0] NT_G = 2'b01;
  localparam logic [1:0] NT_T = 2'b10;
  localparam logic [1:0] NT_C = 2'b11;

  localparam int MATCH_SCORE    = 5;
  localparam int MISMATCH_SCORE = -4;
  localparam int GOPEN          = 8;
  localparam int GEXT           = 1;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_QLEN     = 2'b01;
  localparam logic [1:0] ERR_UNDERRUN = 2'b10;
  localparam logic [1:0] ERR_DRAIN    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARST,
    ST_LOADQ,
    ST_STREAM,
    ST_DRAIN,
    ST_REPORT
  } state_t;

  // Remove the bias; anything below neutral (possible in global mode) floors to zero.
  function automatic logic [SCORE_WIDTH-2:0] unbias(input logic [SCORE_WIDTH-1:0] s);
    logic [SCORE_WIDTH-1:0] d;
    d = s - NEUTRAL_SCORE;
    if (s >= NEUTRAL_SCORE) return d[SCORE_WIDTH-2:0];
    else return '0;
  endfunction

endpackage

// File: rtl/sw_array_driver_shifter.sv
// Query preload shift register: new chars enter at the top, so after N_PE shifts
// the first accepted char sits in the PE0 slot (bits [1:0]).
module sw_preload_shifter #(
  parameter int N_PE = 48
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [1:0]        din,
  output logic [2*N_PE-1:0] q
);

  always_ff @(posedge clk) begin
    if (i_rst || clr) q <= '0;
    else if (shift_en) q <= {din, q[2*N_PE-1:2]};
  end

endmodule

// File: rtl/sw_array_driver.sv
// Head/tail controller for the affine Smith-Waterman PE chain: resets the array, preloads
// the query, streams the target gapless into PE0 and reports one best score per job.
module sw_array_driver
  import sw_pkg::*;
#(
  parameter int N_PE      = 48,
  parameter int TLEN_W    = 16,
  parameter int DRAIN_PAD = 4
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_local,
  input  logic [1:0]             s_q_data,
  input  logic                   s_q_vld,
  input  logic                   s_q_last,
  output logic                   s_q_rdy,
  input  logic [1:0]             s_t_data,
  input  logic                   s_t_vld,
  input  logic                   s_t_last,
  output logic                   s_t_rdy,
  output logic                   o_arr_rst,
  output logic [1:0]             o_arr_data,
  output logic                   o_arr_vld,
  output logic                   o_arr_local,
  output logic [2*N_PE-1:0]      o_arr_preload,
  input  logic [SCORE_WIDTH-1:0] i_arr_high,
  input  logic                   i_arr_vld,
  output logic [SCORE_WIDTH-2:0] m_score,
  output logic [1:0]             m_err,
  output logic                   m_vld,
  input  logic                   m_rdy,
  output logic [2:0]             dbg_state
);

  localparam int AW = $clog2(N_PE + 3);
  localparam int QW = $clog2(N_PE + 1);
  localparam int DW = $clog2(N_PE + DRAIN_PAD + 1);
  localparam logic [TLEN_W-1:0] TLEN_MAX = '1;

  // All ports use valid/ready: a transfer happens on a rising clk edge where both are 1;
  // a source holds data/last stable while valid is up and ready is low.

  state_t                 state, state_nx;
  logic [AW-1:0]          arst_cnt;
  logic [QW-1:0]          q_cnt;
  logic [TLEN_W-1:0]      t_cnt;
  logic [DW-1:0]          drain_cnt;
  logic                   t_started;
  logic                   arr_vld_q;
  logic [SCORE_WIDTH-1:0] max_q, max_nx;
  logic                   err_set;
  logic [1:0]             err_nx;
  logic                   q_hs, t_hs, q_at_end, t_last_eff, arr_fall, drain_to;

  assign q_hs       = (state == ST_LOADQ) && s_q_vld;
  assign t_hs       = (state == ST_STREAM) && s_t_vld;
  assign q_at_end   = (q_cnt == QW'(N_PE - 1));
  assign t_last_eff = s_t_last || (t_cnt == TLEN_MAX - 1'b1);
  assign arr_fall   = arr_vld_q && !i_arr_vld;
  assign drain_to   = (drain_cnt == DW'(N_PE + DRAIN_PAD - 1));
  assign max_nx     = (i_arr_vld && (i_arr_high > max_q)) ? i_arr_high : max_q;
  assign dbg_state  = state;

  sw_preload_shifter #(.N_PE(N_PE)) u_preload (
    .clk      (clk),
    .i_rst    (i_rst),
    .clr      (state == ST_IDLE),
    .shift_en (q_hs),
    .din      (s_q_data),
    .q        (o_arr_preload)
  );

  always_comb begin
    state_nx  = state;
    err_set   = 1'b0;
    err_nx    = ERR_OK;
    o_arr_rst = 1'b0;
    s_q_rdy   = 1'b0;
    s_t_rdy   = 1'b0;
    m_vld     = 1'b0;
    case (state)
      ST_IDLE: begin
        o_arr_rst = 1'b1;
        state_nx  = ST_ARST;
      end
      ST_ARST: begin
        // N_PE+1 reset cycles ripple through the chain, then two idle cycles settle it.
        o_arr_rst = (arst_cnt < AW'(N_PE + 1));
        if (arst_cnt == AW'(N_PE + 2)) state_nx = ST_LOADQ;
      end
      ST_LOADQ: begin
        s_q_rdy = 1'b1;
        if (q_hs) begin
          if (s_q_last && q_at_end) begin
            state_nx = ST_STREAM;
          end else if (s_q_last || q_at_end) begin
            err_set  = 1'b1;
            err_nx   = ERR_QLEN;
            state_nx = ST_REPORT;
          end
        end
      end
      ST_STREAM: begin
        s_t_rdy = 1'b1;
        if (t_hs && t_last_eff) begin
          state_nx = ST_DRAIN;
        end else if (!s_t_vld && t_started) begin
          err_set  = 1'b1;
          err_nx   = ERR_UNDERRUN;
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (arr_fall) begin
          state_nx = ST_REPORT;
        end else if (drain_to) begin
          err_set  = 1'b1;
          err_nx   = ERR_DRAIN;
          state_nx = ST_REPORT;
        end
      end
      ST_REPORT: begin
        m_vld = 1'b1;
        if (m_rdy) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      arst_cnt    <= '0;
      q_cnt       <= '0;
      t_cnt       <= '0;
      drain_cnt   <= '0;
      t_started   <= 1'b0;
      arr_vld_q   <= 1'b0;
      max_q       <= NEUTRAL_SCORE;
      o_arr_vld   <= 1'b0;
      o_arr_data  <= NT_A;
      o_arr_local <= 1'b0;
      m_score     <= '0;
      m_err       <= ERR_OK;
    end else begin
      state     <= state_nx;
      arr_vld_q <= i_arr_vld;
      max_q     <= max_nx;
      o_arr_vld <= t_hs;
      if (t_hs) o_arr_data <= s_t_data;
      case (state)
        ST_IDLE: begin
          arst_cnt    <= '0;
          q_cnt       <= '0;
          t_cnt       <= '0;
          drain_cnt   <= '0;
          t_started   <= 1'b0;
          arr_vld_q   <= 1'b0;
          max_q       <= NEUTRAL_SCORE;
          m_err       <= ERR_OK;
          o_arr_local <= i_local;
        end
        ST_ARST:  arst_cnt <= arst_cnt + 1'b1;
        ST_LOADQ: if (q_hs) q_cnt <= q_cnt + 1'b1;
        ST_STREAM: begin
          if (t_hs) begin
            t_started <= 1'b1;
            if (t_cnt != TLEN_MAX) t_cnt <= t_cnt + 1'b1;
          end
        end
        ST_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
      if (err_set) m_err <= err_nx;
      // Freeze the score as REPORT is entered so it cannot move while the consumer stalls.
      if ((state != ST_REPORT) && (state_nx == ST_REPORT)) m_score <= unbias(max_nx);
    end
  end

endmodule

// File: tb/tb_sw_array_driver.sv
// Bench for sw_array_driver with N_PE=4: a behavioural 4-PE chain model feeds the tail
// inputs; jobs come from a vector table plus hand-written underrun and reset sequences.
module tb_sw_array_driver;
  import sw_pkg::*;

  localparam int NPE = 4;

  logic                   clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic                   i_local = 1'b1;
  logic [1:0]             s_q_data = '0;
  logic                   s_q_vld = 1'b0;
  logic                   s_q_last = 1'b0;
  logic                   s_q_rdy;
  logic [1:0]             s_t_data = '0;
  logic                   s_t_vld = 1'b0;
  logic                   s_t_last = 1'b0;
  logic                   s_t_rdy;
  logic                   o_arr_rst;
  logic [1:0]             o_arr_data;
  logic                   o_arr_vld;
  logic                   o_arr_local;
  logic [2*NPE-1:0]       o_arr_preload;
  logic [SCORE_WIDTH-1:0] arr_high;
  logic                   arr_vld;
  logic [SCORE_WIDTH-2:0] m_score;
  logic [1:0]             m_err;
  logic                   m_vld;
  logic                   m_rdy = 1'b0;
  logic [2:0]             dbg_state;

  sw_array_driver #(.N_PE(NPE), .TLEN_W(16), .DRAIN_PAD(4)) dut (
    .clk(clk), .i_rst(i_rst), .i_local(i_local),
    .s_q_data(s_q_data), .s_q_vld(s_q_vld), .s_q_last(s_q_last), .s_q_rdy(s_q_rdy),
    .s_t_data(s_t_data), .s_t_vld(s_t_vld), .s_t_last(s_t_last), .s_t_rdy(s_t_rdy),
    .o_arr_rst(o_arr_rst), .o_arr_data(o_arr_data), .o_arr_vld(o_arr_vld),
    .o_arr_local(o_arr_local), .o_arr_preload(o_arr_preload),
    .i_arr_high(arr_high), .i_arr_vld(arr_vld),
    .m_score(m_score), .m_err(m_err), .m_vld(m_vld), .m_rdy(m_rdy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- PE chain model ----------------
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Running best local affine score over query qv (PE k = qv[2k+1:2k]) and target prefix tv[0..n-1].
  function automatic int sw_best(input logic [7:0] qv, input int tv[16], input int n);
    int h [5][17];
    int e [5][17];
    int f [5][17];
    int best, s, m;
    logic [1:0] qc;
    best = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 17; j++) begin
        h[i][j] = 0; e[i][j] = -1000; f[i][j] = -1000;
      end
    for (int j = 1; j <= n && j <= 16; j++)
      for (int i = 1; i <= 4; i++) begin
        qc = qv[2*(i-1) +: 2];
        s = (int'(qc) == tv[j-1]) ? MATCH_SCORE : MISMATCH_SCORE;
        e[i][j] = max2(h[i][j-1] - GOPEN, e[i][j-1] - GEXT);
        f[i][j] = max2(h[i-1][j] - GOPEN, f[i-1][j] - GEXT);
        m = max2(0, h[i-1][j-1] + s);
        m = max2(m, e[i][j]);
        m = max2(m, f[i][j]);
        h[i][j] = m;
        best = max2(best, m);
      end
    return best;
  endfunction

  logic [NPE-1:0] dv = '0;
  int dpos [NPE];
  int tgt [16];
  int tlen = 0;
  bit mute = 1'b0;

  always @(posedge clk) begin
    if (o_arr_rst) begin
      dv   <= '0;
      tlen <= 0;
    end else begin
      dv      <= {dv[NPE-2:0], o_arr_vld};
      dpos[0] <= tlen + 1;
      for (int k = 1; k < NPE; k++) dpos[k] <= dpos[k-1];
      if (o_arr_vld && tlen < 16) begin
        tgt[tlen] <= int'(o_arr_data);
        tlen      <= tlen + 1;
      end
    end
  end

  // Invalid cycles carry a large junk value the driver must ignore.
  always_comb begin
    arr_vld  = dv[NPE-1] && !mute;
    arr_high = 11'h7FF;
    if (arr_vld) arr_high = 11'(1024 + sw_best(o_arr_preload, tgt, dpos[NPE-1]));
  end

  // ---------------- monitors ----------------
  int t_rdy_cycles = 0;
  int arr_vld_cycles = 0;
  always @(negedge clk) begin
    if (s_t_rdy) t_rdy_cycles <= t_rdy_cycles + 1;
    if (o_arr_vld) arr_vld_cycles <= arr_vld_cycles + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [1:0] enc1(input byte c);
    case (c)
      "A": return NT_A;
      "G": return NT_G;
      "T": return NT_T;
      default: return NT_C;
    endcase
  endfunction

  function automatic logic [15:0] enc(input string s);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < 8; i++) r[2*i +: 2] = enc1(s[i]);
    return r;
  endfunction

  task automatic drive_q_char(input logic [1:0] c, input logic last, output bit ok);
    int cnt;
    cnt = 0;
    s_q_data = c; s_q_last = last; s_q_vld = 1'b1;
    while (!s_q_rdy && cnt < 100) begin @(negedge clk); cnt++; end
    ok = s_q_rdy;
    @(negedge clk);
  endtask

  task automatic drive_t_char(input logic [1:0] c, input logic last, output bit ok);
    int cnt;
    cnt = 0;
    s_t_data = c; s_t_last = last; s_t_vld = 1'b1;
    while (!s_t_rdy && cnt < 100) begin @(negedge clk); cnt++; end
    ok = s_t_rdy;
    @(negedge clk);
  endtask

  task automatic send_query(input string q, input int qlast);
    bit ok;
    for (int i = 0; i < q.len(); i++) begin
      drive_q_char(enc1(q[i]), (i == qlast), ok);
      if (!ok) begin check("q_handshake_timeout", 0, 1); break; end
    end
    s_q_vld = 1'b0; s_q_last = 1'b0;
  endtask

  task automatic send_target(input string t);
    bit ok;
    for (int i = 0; i < t.len(); i++) begin
      drive_t_char(enc1(t[i]), (i == t.len() - 1), ok);
      if (!ok) begin check("t_handshake_timeout", 0, 1); break; end
    end
    s_t_vld = 1'b0; s_t_last = 1'b0;
  endtask

  task automatic wait_result(input int hold);
    logic [11:0] e;
    int cnt;
    cnt = 0;
    while (!m_vld && cnt < 300) begin @(negedge clk); cnt++; end
    if (!m_vld) begin
      check("result_timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < hold; k++) begin
      check("hold_m_vld", 32'(m_vld), 1);
      check("hold_m_score", 32'(m_score), 32'(e[11:2]));
      @(negedge clk);
    end
    check("m_score", 32'(m_score), 32'(e[11:2]));
    check("m_err", 32'(m_err), 32'(e[1:0]));
    m_rdy = 1'b1;
    @(negedge clk);
    m_rdy = 1'b0;
    check("m_vld_after_handshake", 32'(m_vld), 0);
    check("state_idle_after_handshake", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  typedef struct {
    string q;
    int    qlast;
    string t;
    int    exp_score;
    int    exp_err;
    int    hold;
    bit    mute;
  } vec_t;

  task automatic run_job(input vec_t v);
    int t_rdy0, vld0;
    t_rdy0 = t_rdy_cycles;
    vld0   = arr_vld_cycles;
    mute   = v.mute;
    exp_q.push_back({10'(v.exp_score), 2'(v.exp_err)});
    send_query(v.q, v.qlast);
    if (v.exp_err != 1) begin
      check("preload", 32'(o_arr_preload), 32'(enc(v.q)));
      check("arr_local", 32'(o_arr_local), 1);
      send_target(v.t);
    end
    wait_result(v.hold);
    if (v.exp_err == 1) begin
      check("qerr_no_t_rdy", 32'(t_rdy_cycles - t_rdy0), 0);
      check("qerr_no_arr_vld", 32'(arr_vld_cycles - vld0), 0);
    end
    mute = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t vecs [7];

  initial begin
    int hi_cnt, lo_cnt;
    bit ok;

    vecs[0] = '{q:"AGTC", qlast:3,  t:"AGTC",     exp_score:20, exp_err:0, hold:0,  mute:0};
    vecs[1] = '{q:"AAAA", qlast:3,  t:"TTTT",     exp_score:0,  exp_err:0, hold:0,  mute:0};
    vecs[2] = '{q:"AGTC", qlast:3,  t:"TTAGTCAA", exp_score:20, exp_err:0, hold:10, mute:0};
    vecs[3] = '{q:"AAAA", qlast:3,  t:"AA",       exp_score:10, exp_err:0, hold:0,  mute:0};
    vecs[4] = '{q:"AGT",  qlast:2,  t:"",         exp_score:0,  exp_err:1, hold:0,  mute:0};
    vecs[5] = '{q:"AGTC", qlast:-1, t:"",         exp_score:0,  exp_err:1, hold:0,  mute:0};
    vecs[6] = '{q:"AGTC", qlast:3,  t:"AGTC",     exp_score:0,  exp_err:3, hold:0,  mute:1};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_arr_rst", 32'(o_arr_rst), 1);
    check("rst_q_rdy", 32'(s_q_rdy), 0);
    check("rst_t_rdy", 32'(s_t_rdy), 0);
    check("rst_m_vld", 32'(m_vld), 0);
    check("rst_arr_vld", 32'(o_arr_vld), 0);
    check("rst_arr_data", 32'(o_arr_data), 0);
    check("rst_preload", 32'(o_arr_preload), 0);
    check("rst_m_score", 32'(m_score), 0);
    check("rst_m_err", 32'(m_err), 0);
    check("rst_arr_local", 32'(o_arr_local), 0);

    // Array reset pulse: IDLE cycle plus N_PE+1 ARST cycles high, then two low before LOADQ.
    i_rst = 1'b0;
    hi_cnt = 0;
    while (o_arr_rst && hi_cnt < 50) begin @(negedge clk); hi_cnt++; end
    lo_cnt = 0;
    while (!s_q_rdy && lo_cnt < 50) begin @(negedge clk); lo_cnt++; end
    check("arst_high_cycles", 32'(hi_cnt), 32'(NPE + 2));
    check("arst_low_cycles", 32'(lo_cnt), 2);

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Underrun: target A,C then a one-cycle gap.
    exp_q.push_back({10'(5), ERR_UNDERRUN});
    send_query("AGTC", 3);
    drive_t_char(NT_A, 1'b0, ok);
    check("ur_hs0", 32'(ok), 1);
    drive_t_char(NT_C, 1'b0, ok);
    check("ur_hs1", 32'(ok), 1);
    check("ur_arr_vld_before_gap", 32'(o_arr_vld), 1);
    s_t_vld = 1'b0;
    @(negedge clk);
    check("ur_arr_vld_dropped", 32'(o_arr_vld), 0);
    check("ur_t_rdy_dropped", 32'(s_t_rdy), 0);
    wait_result(0);

    // Reset mid-stream aborts the job; the next job scores normally.
    send_query("AGTC", 3);
    drive_t_char(NT_A, 1'b0, ok);
    drive_t_char(NT_G, 1'b0, ok);
    i_rst = 1'b1;
    s_t_vld = 1'b0;
    @(negedge clk);
    check("mid_rst_arr_rst", 32'(o_arr_rst), 1);
    check("mid_rst_arr_vld", 32'(o_arr_vld), 0);
    check("mid_rst_m_vld", 32'(m_vld), 0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    i_rst = 1'b0;
    run_job(vecs[0]);

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
